// File: rtl/score_pkg.sv
// Shared types and default sizing for the score sequencer.
package score_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int VAL_W_DEF     = 4;
    localparam int MAX_SCORE_DEF = 99;
    localparam int SCORE_W_DEF   = 7;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARB,
        GRANT,
        PULSE_HI,
        PULSE_LO
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    // Two passes: indices from ptr upward, then the wrapped indices below ptr.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && req[j] && (j >= int'(ptr))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && req[j] && (j < int'(ptr))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Arbitrates score awards and converts each into single-point toggle pulses
// for an edge-triggered BCD counter, tracking a saturating binary shadow total.
module score_sequencer
    import score_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int VAL_W     = VAL_W_DEF,
    parameter int MAX_SCORE = MAX_SCORE_DEF,
    parameter int SCORE_W   = SCORE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gameStart,
    input  logic                     gameOver,
    input  logic [NUM_REQ-1:0]       hitReq,
    input  logic [NUM_REQ*VAL_W-1:0] hitValue,
    output logic [NUM_REQ-1:0]       hitAck,
    output logic                     scoreToggle,
    output logic                     scoreClear,
    output logic [SCORE_W-1:0]       shadowScore,
    output logic                     busy,
    output logic                     saturated
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [VAL_W-1:0]     remaining_q, remaining_d;
    logic [SCORE_W-1:0]   shadow_q, shadow_d;
    logic                 sat_q, sat_d;
    logic [NUM_REQ-1:0]   hit_ack_q, hit_ack_d;
    logic                 toggle_q, toggle_d;
    logic                 clear_q, clear_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic                 arb_valid;
    logic [VAL_W-1:0]     sel_value;
    logic [VAL_W-1:0]     capped_value;
    logic [PTR_W-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (hitReq),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Point value of the latched grant (grant_q is one-hot, so OR-ing is a mux).
    always_comb begin
        sel_value = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) sel_value = sel_value | hitValue[j*VAL_W +: VAL_W];
        end
    end

    // Clip the award to the headroom left below MAX_SCORE so the total never wraps.
    always_comb begin
        int room;
        room = MAX_SCORE - int'(shadow_q);
        if (int'(sel_value) < room) capped_value = sel_value;
        else                        capped_value = VAL_W'(room);
    end

    // Round-robin pointer moves to the requester just after the one granted.
    always_comb begin
        next_ptr = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) next_ptr = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
        end
    end

    // Next-state, datapath updates, and next-state-decoded registered outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        remaining_d = remaining_q;
        shadow_d    = shadow_q;

        case (state_q)
            IDLE: begin
                if (gameStart) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = ARB;
            end
            ARB: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                remaining_d = capped_value;
                rr_ptr_d    = next_ptr;
                state_d     = (capped_value != '0) ? PULSE_HI : ARB;
            end
            PULSE_HI: begin
                // The pulse has already been driven, so it is counted even if
                // the game ends or restarts this cycle.
                shadow_d    = shadow_q + SCORE_W'(1);
                remaining_d = remaining_q - VAL_W'(1);
                state_d     = PULSE_LO;
            end
            PULSE_LO: begin
                state_d = (remaining_q != '0) ? PULSE_HI : ARB;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Game control overrides; in IDLE only gameStart matters, elsewhere gameOver wins.
        if (state_q != IDLE) begin
            if (gameOver) begin
                state_d     = IDLE;
                remaining_d = '0;
            end else if (gameStart) begin
                state_d     = CLEAR;
                remaining_d = '0;
            end
        end

        // Entering CLEAR starts a fresh game: total and arbitration order reset together.
        if (state_d == CLEAR) begin
            shadow_d = '0;
            rr_ptr_d = '0;
        end

        sat_d     = (shadow_d == SCORE_W'(MAX_SCORE));
        hit_ack_d = (state_d == GRANT) ? grant_d : '0;
        toggle_d  = (state_d == PULSE_HI);
        clear_d   = (state_d == CLEAR);
        busy_d    = (state_d == GRANT) || (state_d == PULSE_HI) || (state_d == PULSE_LO);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            remaining_q <= '0;
            shadow_q    <= '0;
            sat_q       <= 1'b0;
            hit_ack_q   <= '0;
            toggle_q    <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            remaining_q <= remaining_d;
            shadow_q    <= shadow_d;
            sat_q       <= sat_d;
            hit_ack_q   <= hit_ack_d;
            toggle_q    <= toggle_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
        end
    end

    assign hitAck      = hit_ack_q;
    assign scoreToggle = toggle_q;
    assign scoreClear  = clear_q;
    assign shadowScore = shadow_q;
    assign busy        = busy_q;
    assign saturated   = sat_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Scoreboard bench for score_sequencer: stimulus queues expected awards,
// a monitor pops them on each hitAck and checks toggles/total/duration.
module tb_score_sequencer;

    localparam int NR = 4;
    localparam int VW = 4;
    localparam int SW = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              gameStart = 1'b0;
    logic              gameOver = 1'b0;
    logic [NR-1:0]     hitReq = '0;
    logic [NR*VW-1:0]  hitValue = '0;
    logic [NR-1:0]     hitAck;
    logic              scoreToggle;
    logic              scoreClear;
    logic [SW-1:0]     shadowScore;
    logic              busy;
    logic              saturated;

    score_sequencer #(
        .NUM_REQ   (NR),
        .VAL_W     (VW),
        .MAX_SCORE (99),
        .SCORE_W   (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gameStart   (gameStart),
        .gameOver    (gameOver),
        .hitReq      (hitReq),
        .hitValue    (hitValue),
        .hitAck      (hitAck),
        .scoreToggle (scoreToggle),
        .scoreClear  (scoreClear),
        .shadowScore (shadowScore),
        .busy        (busy),
        .saturated   (saturated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] ack;
        int            tog;
        int            shadow;
        int            bcyc;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [NR-1:0] pend = '0;
    bit            mon_active = 1'b0;
    exp_t          cur;
    int            tcnt = 0;
    int            bcnt = 0;
    bit            tog_prev = 1'b0;
    bit            busy_prev = 1'b0;
    int            hi_seen;
    int            guard;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One cycle; requesters drop a request one edge after their ack was seen.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (pend[i]) begin
                hitReq[i] = 1'b0;
                pend[i]   = 1'b0;
            end else if (hitAck[i]) begin
                pend[i] = 1'b1;
            end
        end
    endtask

    task automatic pulse(input bit st, input bit ov);
        gameStart = st;
        gameOver  = ov;
        tick();
        gameStart = 1'b0;
        gameOver  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || mon_active || hitReq != '0) && n < 300) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, int'(n < 300), 1);
    endtask

    task automatic award(input int idx, input int val, input int etog, input int esh);
        exp_q.push_back('{ack: NR'(1 << idx), tog: etog, shadow: esh, bcyc: 1 + 2 * etog});
        hitValue[idx*VW +: VW] = VW'(val);
        hitReq[idx] = 1'b1;
        wait_done("award");
    endtask

    // Monitor: pop on each ack, close the award when busy falls.
    initial begin
        cur = '{ack: '0, tog: 0, shadow: 0, bcyc: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                tog_prev   = 1'b0;
                busy_prev  = 1'b0;
            end else begin
                if (hitAck != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", int'(hitAck), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("ack", int'(hitAck), int'(cur.ack));
                        mon_active = 1'b1;
                        tcnt = 0;
                        bcnt = 0;
                    end
                end
                if (scoreToggle && !tog_prev) tcnt++;
                if (busy) bcnt++;
                if (mon_active && busy_prev && !busy) begin
                    chk("toggles", tcnt, cur.tog);
                    chk("shadow", int'(shadowScore), cur.shadow);
                    chk("busy_cycles", bcnt, cur.bcyc);
                    mon_active = 1'b0;
                end
                tog_prev  = scoreToggle;
                busy_prev = busy;
            end
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_ack", int'(hitAck), 0);
        chk("rst_toggle", int'(scoreToggle), 0);
        chk("rst_clear", int'(scoreClear), 0);
        chk("rst_shadow", int'(shadowScore), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sat", int'(saturated), 0);
        reset = 1'b0;

        // IDLE ignores requests and gameOver
        hitValue[0 +: VW] = 4'd2;
        hitReq[0] = 1'b1;
        pulse(1'b0, 1'b1);
        repeat (4) tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_ack", int'(hitAck), 0);
        chk("idle_clear", int'(scoreClear), 0);
        hitReq[0] = 1'b0;

        // start
        pulse(1'b1, 1'b0);
        chk("start_clear", int'(scoreClear), 1);
        chk("start_shadow", int'(shadowScore), 0);
        tick();
        chk("clear_one_cycle", int'(scoreClear), 0);
        chk("arb_busy", int'(busy), 0);

        // single 3-point award from requester 1
        award(1, 3, 3, 3);
        chk("single_sat", int'(saturated), 0);

        // restart mid-game clears total and pointer
        pulse(1'b1, 1'b0);
        chk("restart_clear", int'(scoreClear), 1);
        chk("restart_shadow", int'(shadowScore), 0);
        tick();

        // round robin, two rounds of all four requesters, 1 point each
        hitValue = 16'h1111;
        for (int i = 0; i < NR; i++)
            exp_q.push_back('{ack: NR'(1 << i), tog: 1, shadow: i + 1, bcyc: 3});
        hitReq = '1;
        wait_done("rr1");
        for (int i = 0; i < NR; i++)
            exp_q.push_back('{ack: NR'(1 << i), tog: 1, shadow: i + 5, bcyc: 3});
        hitReq = '1;
        wait_done("rr2");

        // climb to 97, then saturate
        award(0, 15, 15, 23);
        award(1, 15, 15, 38);
        award(2, 15, 15, 53);
        award(3, 15, 15, 68);
        award(0, 15, 15, 83);
        award(1, 14, 14, 97);
        chk("sat_at_97", int'(saturated), 0);
        award(2, 5, 2, 99);
        chk("sat_at_99", int'(saturated), 1);
        award(3, 4, 0, 99);
        chk("sat_hold", int'(shadowScore), 99);

        // gameOver in ARB keeps the total
        pulse(1'b0, 1'b1);
        chk("over_shadow", int'(shadowScore), 99);
        chk("over_sat", int'(saturated), 1);
        pulse(1'b1, 1'b0);
        chk("start2_clear", int'(scoreClear), 1);
        chk("start2_shadow", int'(shadowScore), 0);
        chk("start2_sat", int'(saturated), 0);
        tick();

        // 6-point award abandoned in PULSE_LO after 2 points
        exp_q.push_back('{ack: 4'b0100, tog: 2, shadow: 2, bcyc: 5});
        hitValue[2*VW +: VW] = 4'd6;
        hitReq[2] = 1'b1;
        hi_seen = 0;
        guard = 0;
        while (!(hi_seen == 2 && !scoreToggle) && guard < 100) begin
            tick();
            if (scoreToggle) hi_seen++;
            guard++;
        end
        chk("abandon_reached", int'(guard < 100), 1);
        pulse(1'b0, 1'b1);
        chk("abandon_busy", int'(busy), 0);
        chk("abandon_toggle", int'(scoreToggle), 0);
        tick();
        chk("abandon_toggle2", int'(scoreToggle), 0);
        repeat (3) tick();
        chk("abandon_shadow", int'(shadowScore), 2);
        pulse(1'b1, 1'b0);
        chk("start3_clear", int'(scoreClear), 1);
        chk("start3_shadow", int'(shadowScore), 0);
        tick();

        // zero-value award is acked and discarded
        award(1, 0, 0, 0);

        // start+over together outside IDLE: over wins, no clear
        pulse(1'b1, 1'b1);
        chk("both_arb_clear", int'(scoreClear), 0);
        hitValue[3*VW +: VW] = 4'd1;
        hitReq[3] = 1'b1;
        repeat (4) tick();
        chk("both_arb_idle_ack", int'(hitAck), 0);
        chk("both_arb_idle_busy", int'(busy), 0);
        hitReq[3] = 1'b0;

        // start+over together in IDLE: start wins
        pulse(1'b1, 1'b1);
        chk("both_idle_clear", int'(scoreClear), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Sits between the game's score sources (asteroid hits, bonus pickups) and the edge-triggered two-digit BCD score counter.
- Arbitrates round-robin among NUM_REQ requesters, each carrying a point value.
- Converts each granted value into that many single-point toggle pulses, spaced so the counter sees clean rising edges.
- Handles game start/clear and game over, and saturates at MAX_SCORE via a binary shadow total.

Parameters:
NUM_REQ, 4, number of score requesters
VAL_W, 4, width of each requester's point value (0..15 points per award)
MAX_SCORE, 99, saturation limit (two BCD digits)
SCORE_W, 7, width of shadow total; must satisfy 2**SCORE_W > MAX_SCORE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
gameStart  in  1  single-cycle pulse; begin new game
gameOver  in  1  single-cycle pulse; end current game
hitReq  in  NUM_REQ  per-requester request, held high until acked
hitValue  in  NUM_REQ*VAL_W  flattened point values; slice i = bits [i*VAL_W +: VAL_W]; must be stable while hitReq[i] high
hitAck  out  NUM_REQ  one-hot, one-cycle grant acknowledge
scoreToggle  out  1  drives the score counter toggle input; one point per rising edge
scoreClear  out  1  one-cycle clear pulse to the score counter
shadowScore  out  SCORE_W  binary running total of points issued this game
busy  out  1  high while an award is being issued
saturated  out  1  high when shadowScore == MAX_SCORE

Behaviour:
- Clock, reset: one clock; reset is synchronous and active-high.
- All outputs registered. Reset: state IDLE; hitAck=0, scoreToggle=0, scoreClear=0, shadowScore=0, busy=0, saturated=0; rrPtr=0; remaining=0.
- States: IDLE, CLEAR, ARB, GRANT, PULSE_HI, PULSE_LO.
- IDLE:
  - hitReq ignored; no ack.
  - gameOver ignored.
  - gameStart -> CLEAR.
- CLEAR (1 cycle):
  - scoreClear=1; shadowScore<=0; rrPtr<=0.
  - Next state: ARB.
- ARB:
  - Searches hitReq starting at index rrPtr, wrapping modulo NUM_REQ.
  - First set bit g is latched as the grant; next state GRANT.
  - No request: stay in ARB.
- GRANT (1 cycle):
  - hitAck[g]=1; all other bits 0.
  - remaining <= min(hitValue[g], MAX_SCORE - shadowScore).
  - rrPtr <= (g+1) mod NUM_REQ.
  - Next state: PULSE_HI if the computed remaining is nonzero, else ARB.
  - A zero-value or post-saturation award is still acked, then discarded.
- Requester rule: deassert hitReq[i] on the edge following the cycle hitAck[i] is seen. ARB therefore never re-grants the same request.
- PULSE_HI (1 cycle):
  - scoreToggle=1.
  - On exit: shadowScore+=1, remaining-=1.
  - Next state: PULSE_LO.
- PULSE_LO (1 cycle):
  - scoreToggle=0.
  - Next state: PULSE_HI if remaining != 0, else ARB.
- Timing: an award of V points takes 1 (GRANT) + 2V cycles. Toggle period is 2 cycles at 50% duty.
- busy=1 in GRANT, PULSE_HI and PULSE_LO.
- saturated tracks shadowScore == MAX_SCORE, registered alongside shadowScore.
- shadowScore never exceeds MAX_SCORE; no wrap. scoreToggle never pulses once saturated.
- gameOver in any non-IDLE state:
  - Next state IDLE; remaining points abandoned.
  - scoreToggle=0 next cycle; any pulse already high completes its single high cycle.
  - shadowScore retains its value for display.
- gameStart in any non-IDLE state (with no gameOver that cycle): restart -> CLEAR; in-flight award abandoned.
- gameStart and gameOver in the same cycle:
  - In a non-IDLE state, gameOver wins.
  - In IDLE, gameStart wins.
- reset mid-award: immediate return to reset values. The BCD counter is not cleared by reset; the next gameStart issues scoreClear.

Decomposition:
- Package score_pkg holds:
  - state enum (IDLE, CLEAR, ARB, GRANT, PULSE_HI, PULSE_LO);
  - MAX_SCORE default of 99;
  - SCORE_W and VAL_W defaults.
- One sub-module, rr_arbiter:
  - inputs: req vector and pointer;
  - outputs: one-hot grant and valid;
  - purely combinational priority rotate.
- Pointer register and FSM stay in score_sequencer.

Test Plan:
- Reset, then gameStart -> scoreClear high exactly 1 cycle, shadowScore=0, state ARB; hitReq ignored while in IDLE before start.
- Single award: hitReq[1]=1, value 3 -> hitAck=4'b0010 for 1 cycle, then scoreToggle 1,0,1,0,1,0; shadowScore=3; ARB reached 7 cycles after GRANT start.
- Round-robin: hitReq=4'b1111, all values 1, held per rule -> grants in order 0,1,2,3; then re-raise all -> 0 again; each requester acked exactly once per round.
- Saturation: preload shadowScore to 97 via awards, then value 5 -> exactly 2 toggles, shadowScore=99, saturated=1; next value-4 award acked with zero toggles.
- gameOver during PULSE_LO of a 6-point award after 2 points -> IDLE next cycle, no further toggles, shadowScore=2 held; a following gameStart issues scoreClear and resets shadowScore to 0.
- Zero-value award and simultaneous gameStart+gameOver in ARB -> value 0 acked, no toggle, back to ARB; the combined pulse goes to IDLE with no scoreClear.
